// File: rtl/frame_decapsulation_module.sv
// rtl/frame_decapsulation_module.sv - strips TSMP encapsulation and routes inner ARP/PTP and NMAC frames
// A one-word hold register gives the two-cycle input-to-output latency and lets a frame end be re-tagged on a gap.
module frame_decapsulation_module (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [133:0] iv_data,
  input  logic         i_data_wr,
  output logic [133:0] ov_data,
  output logic         o_data_wr,
  output logic [133:0] ov_nmac_data,
  output logic         o_nmac_wr,
  output logic         o_trunc_pulse,
  output logic [15:0]  ov_tsmp_cnt,
  output logic [15:0]  ov_discard_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HEAD     = 3'd1;
  localparam logic [2:0] FWD_PORT = 3'd2;
  localparam logic [2:0] FWD_NMAC = 3'd3;
  localparam logic [2:0] DISCARD  = 3'd4;

  localparam logic [1:0] TAG_FIRST = 2'b01;
  localparam logic [1:0] TAG_MID   = 2'b11;
  localparam logic [1:0] TAG_LAST  = 2'b10;

  logic [2:0]   state, state_n;
  logic         hold_valid, hold_valid_n;
  logic [133:0] hold_data, hold_data_n;
  logic         hold_nmac, hold_nmac_n;
  logic         first_pending, first_n;

  logic         emit;
  logic [133:0] emit_word;
  logic         trunc;
  logic         tsmp_inc, disc_inc;

  logic [1:0]   in_tag;
  logic [15:0]  head_type;
  logic [7:0]   head_sub;
  logic [7:0]   head_outport;
  logic         sub_port, sub_nmac, head_port, head_ok;
  logic [8:0]   port_mask;
  logic [133:0] meta_word;

  assign in_tag       = iv_data[133:132];
  assign head_type    = iv_data[31:16];
  assign head_sub     = iv_data[15:8];
  assign head_outport = iv_data[7:0];

  always_comb begin
    sub_port  = (head_sub == 8'h00) || (head_sub == 8'h05);
    sub_nmac  = (head_sub == 8'h01);
    head_port = sub_port && (head_outport <= 8'd8);
    head_ok   = i_data_wr && (in_tag == TAG_MID) && (head_type == 16'hff01)
                && (head_port || sub_nmac);
    port_mask = 9'd1 << head_outport[3:0];
    meta_word = {6'b010000, 3'b110, 5'd0, port_mask, 1'b0, 1'b1, 109'd0};
  end

  always_comb begin
    state_n      = state;
    hold_valid_n = hold_valid;
    hold_data_n  = hold_data;
    hold_nmac_n  = hold_nmac;
    first_n      = first_pending;
    emit         = 1'b0;
    emit_word    = hold_data;
    trunc        = 1'b0;
    tsmp_inc     = 1'b0;
    disc_inc     = 1'b0;
    case (state)
      IDLE: begin
        // Drain the last word of the previous frame while a new one may already start.
        emit         = hold_valid;
        hold_valid_n = 1'b0;
        if (i_data_wr && (in_tag == TAG_FIRST)) begin
          state_n = HEAD;
        end
      end
      HEAD: begin
        if (head_ok) begin
          tsmp_inc = 1'b1;
          first_n  = 1'b1;
          if (head_port) begin
            hold_valid_n = 1'b1;
            hold_data_n  = meta_word;
            hold_nmac_n  = 1'b0;
            state_n      = FWD_PORT;
          end else begin
            hold_nmac_n = 1'b1;
            state_n     = FWD_NMAC;
          end
        end else begin
          disc_inc = 1'b1;
          state_n  = (!i_data_wr || (in_tag == TAG_LAST)) ? IDLE : DISCARD;
        end
      end
      FWD_PORT, FWD_NMAC: begin
        if (!i_data_wr || (in_tag == TAG_FIRST)) begin
          emit         = hold_valid;
          trunc        = hold_valid;
          emit_word    = {TAG_LAST, 4'd0, hold_data[127:0]};
          hold_valid_n = 1'b0;
          state_n      = IDLE;
        end else begin
          emit         = hold_valid;
          hold_valid_n = 1'b1;
          hold_data_n  = iv_data;
          if (first_pending && (in_tag != TAG_LAST)) begin
            hold_data_n[133:132] = hold_nmac ? TAG_FIRST : TAG_MID;
          end
          first_n = 1'b0;
          if (in_tag == TAG_LAST) begin
            state_n = IDLE;
          end
        end
      end
      DISCARD: begin
        if (!i_data_wr || (in_tag == TAG_LAST)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      hold_valid     <= 1'b0;
      hold_data      <= '0;
      hold_nmac      <= 1'b0;
      first_pending  <= 1'b0;
      ov_data        <= '0;
      o_data_wr      <= 1'b0;
      ov_nmac_data   <= '0;
      o_nmac_wr      <= 1'b0;
      o_trunc_pulse  <= 1'b0;
      ov_tsmp_cnt    <= '0;
      ov_discard_cnt <= '0;
    end else begin
      state         <= state_n;
      hold_valid    <= hold_valid_n;
      hold_data     <= hold_data_n;
      hold_nmac     <= hold_nmac_n;
      first_pending <= first_n;
      o_data_wr     <= emit && !hold_nmac;
      o_nmac_wr     <= emit && hold_nmac;
      o_trunc_pulse <= trunc;
      if (emit && !hold_nmac) begin
        ov_data <= emit_word;
      end
      if (emit && hold_nmac) begin
        ov_nmac_data <= emit_word;
      end
      if (tsmp_inc) begin
        ov_tsmp_cnt <= ov_tsmp_cnt + 16'd1;
      end
      if (disc_inc) begin
        ov_discard_cnt <= ov_discard_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_decapsulation_module.sv
// tb/tb_frame_decapsulation_module.sv - directed frames checked against a frame-level reference model
// The model turns each stimulus table into per-cycle expected outputs; a negedge process compares every cycle.
module tb_frame_decapsulation_module;

  localparam int MAXC = 64;
  localparam logic [133:0] PIN_META3 = {6'b010000, 3'b110, 5'd0, 9'h008, 1'b0, 1'b1, 109'd0};

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [133:0] iv_data = '0;
  logic         i_data_wr = 1'b0;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [133:0] ov_nmac_data;
  logic         o_nmac_wr;
  logic         o_trunc_pulse;
  logic [15:0]  ov_tsmp_cnt;
  logic [15:0]  ov_discard_cnt;

  frame_decapsulation_module dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .iv_data        (iv_data),
    .i_data_wr      (i_data_wr),
    .ov_data        (ov_data),
    .o_data_wr      (o_data_wr),
    .ov_nmac_data   (ov_nmac_data),
    .o_nmac_wr      (o_nmac_wr),
    .o_trunc_pulse  (o_trunc_pulse),
    .ov_tsmp_cnt    (ov_tsmp_cnt),
    .ov_discard_cnt (ov_discard_cnt)
  );

  always #5 i_clk = ~i_clk;

  logic         s_wr   [MAXC];
  logic [133:0] s_d    [MAXC];
  int           n_stim;
  logic         exp_pw [MAXC];
  logic [133:0] exp_pd [MAXC];
  logic         exp_nw [MAXC];
  logic [133:0] exp_nd [MAXC];
  logic         exp_tr [MAXC];
  logic [15:0]  exp_tc [MAXC];
  logic [15:0]  exp_dc [MAXC];
  logic [15:0]  m_tsmp, m_disc;
  int           n_checks = 0;
  int           n_err = 0;
  int           cyc = 0;
  bit           chk_en = 1'b0;
  logic [133:0] got_port[$];
  logic [133:0] got_nmac[$];
  int           trunc_seen;

  task automatic chk(input string nm, input logic [133:0] got, input logic [133:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      s_wr[k] = 1'b0;
      s_d[k]  = '0;
    end
    n_stim = 0;
    got_port.delete();
    got_nmac.delete();
    trunc_seen = 0;
  endtask

  task automatic add(input logic wr, input logic [133:0] d);
    s_wr[n_stim] = wr;
    s_d[n_stim]  = d;
    n_stim++;
  endtask

  task automatic add_meta();
    add(1'b1, {2'b01, 4'd0, 96'h5a5a_0000_1111_2222_3333_4444, 32'(n_stim)});
  endtask

  task automatic add_head(input logic [15:0] typ, input logic [7:0] sub, input logic [7:0] op);
    add(1'b1, {2'b11, 4'd0, 48'h0011_2233_4455, 48'h6677_8899_aabb, typ, sub, op});
  endtask

  task automatic add_inner(input logic [1:0] tag, input logic [3:0] inv);
    add(1'b1, {tag, inv, 96'hc0de_0000_abcd_0000_1234_5678, 32'(n_stim + 100)});
  endtask

  task automatic add_gap();
    add(1'b0, {2'b11, 4'd3, 128'hdead_beef});
  endtask

  function automatic logic [133:0] meta_of(input logic [7:0] op);
    logic [8:0] m;
    m = '0;
    m[op[3:0]] = 1'b1;
    return {6'b010000, 3'b110, 5'd0, m, 1'b0, 1'b1, 109'd0};
  endfunction

  function automatic logic head_good(input int h);
    logic [7:0] sub;
    logic [7:0] op;
    sub = s_d[h][15:8];
    op  = s_d[h][7:0];
    return s_wr[h] && (s_d[h][133:132] == 2'b11) && (s_d[h][31:16] == 16'hff01)
           && ((((sub == 8'h00) || (sub == 8'h05)) && (op <= 8'd8)) || (sub == 8'h01));
  endfunction

  task automatic put(input int slot, input logic p, input logic [133:0] w);
    if (p) begin
      exp_pw[slot] = 1'b1;
      exp_pd[slot] = w;
    end else begin
      exp_nw[slot] = 1'b1;
      exp_nd[slot] = w;
    end
  endtask

  // Every word leaves two cycles after it arrived; a truncation just rewrites the word already due next cycle.
  task automatic run_model();
    int i, h, j;
    logic p, first;
    logic [133:0] w;
    for (int k = 0; k < MAXC; k++) begin
      exp_pw[k] = 1'b0; exp_pd[k] = '0; exp_nw[k] = 1'b0; exp_nd[k] = '0;
      exp_tr[k] = 1'b0; exp_tc[k] = m_tsmp; exp_dc[k] = m_disc;
    end
    i = 0;
    while (i < n_stim) begin
      if (!(s_wr[i] && (s_d[i][133:132] == 2'b01))) begin
        i++;
        continue;
      end
      h = i + 1;
      if (!head_good(h)) begin
        for (int k = h + 1; k < MAXC; k++) exp_dc[k]++;
        m_disc++;
        if (!s_wr[h] || (s_d[h][133:132] == 2'b10)) i = h + 1;
        else begin
          j = h + 1;
          while ((j < MAXC - 1) && s_wr[j] && (s_d[j][133:132] != 2'b10)) j++;
          i = j + 1;
        end
        continue;
      end
      for (int k = h + 1; k < MAXC; k++) exp_tc[k]++;
      m_tsmp++;
      p = (s_d[h][15:8] != 8'h01);
      if (p) put(h + 2, 1'b1, meta_of(s_d[h][7:0]));
      first = 1'b1;
      j = h + 1;
      while (j < MAXC - 2) begin
        if (!s_wr[j] || (s_d[j][133:132] == 2'b01)) begin
          if (p && exp_pw[j + 1]) begin
            exp_pd[j + 1][133:128] = 6'b100000;
            exp_tr[j + 1] = 1'b1;
          end else if (!p && exp_nw[j + 1]) begin
            exp_nd[j + 1][133:128] = 6'b100000;
            exp_tr[j + 1] = 1'b1;
          end
          break;
        end
        w = s_d[j];
        if (first && (w[133:132] != 2'b10)) w[133:132] = p ? 2'b11 : 2'b01;
        first = 1'b0;
        put(j + 2, p, w);
        if (s_d[j][133:132] == 2'b10) break;
        j++;
      end
      i = j + 1;
    end
  endtask

  task automatic run_test();
    run_model();
    for (int k = 0; k < n_stim + 3; k++) begin
      @(posedge i_clk);
      #1;
      cyc       = k;
      i_data_wr = s_wr[k];
      iv_data   = s_d[k];
      chk_en    = 1'b1;
    end
    @(negedge i_clk);
    #1;
    chk_en = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("data_wr", 134'(o_data_wr), 134'(exp_pw[cyc]));
      if (o_data_wr && exp_pw[cyc]) chk("data", ov_data, exp_pd[cyc]);
      chk("nmac_wr", 134'(o_nmac_wr), 134'(exp_nw[cyc]));
      if (o_nmac_wr && exp_nw[cyc]) chk("nmac_data", ov_nmac_data, exp_nd[cyc]);
      chk("trunc", 134'(o_trunc_pulse), 134'(exp_tr[cyc]));
      chk("tsmp_cnt", 134'(ov_tsmp_cnt), 134'(exp_tc[cyc]));
      chk("discard_cnt", 134'(ov_discard_cnt), 134'(exp_dc[cyc]));
      if (o_data_wr) got_port.push_back(ov_data);
      if (o_nmac_wr) got_nmac.push_back(ov_nmac_data);
      if (o_trunc_pulse) trunc_seen++;
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_data"}, ov_data, 134'd0);
    chk({nm, "_data_wr"}, 134'(o_data_wr), 134'd0);
    chk({nm, "_nmac"}, ov_nmac_data, 134'd0);
    chk({nm, "_nmac_wr"}, 134'(o_nmac_wr), 134'd0);
    chk({nm, "_trunc"}, 134'(o_trunc_pulse), 134'd0);
    chk({nm, "_tsmp"}, 134'(ov_tsmp_cnt), 134'd0);
    chk({nm, "_disc"}, 134'(ov_discard_cnt), 134'd0);
  endtask

  initial begin
    m_tsmp = '0;
    m_disc = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    i_rst_n = 1'b1;

    // PTP to port 3
    clear_stim();
    add_meta(); add_head(16'hff01, 8'h05, 8'h03);
    add_inner(2'b11, 4'd0); add_inner(2'b11, 4'd0); add_inner(2'b10, 4'd4);
    run_test();
    chk("ptp_len", 134'(got_port.size()), 134'd4);
    if (got_port.size() == 4) begin
      chk("ptp_meta", got_port[0], PIN_META3);
      chk("ptp_tag1", 134'(got_port[1][133:132]), 134'(2'b11));
      chk("ptp_last", 134'(got_port[3][133:128]), 134'(6'b100100));
    end
    chk("ptp_tsmp", 134'(ov_tsmp_cnt), 134'd1);

    // NMAC
    clear_stim();
    add_meta(); add_head(16'hff01, 8'h01, 8'h00);
    add_inner(2'b11, 4'd0); add_inner(2'b10, 4'd2);
    run_test();
    chk("nmac_len", 134'(got_nmac.size()), 134'd2);
    chk("nmac_port_len", 134'(got_port.size()), 134'd0);
    if (got_nmac.size() == 2) begin
      chk("nmac_tag0", 134'(got_nmac[0][133:132]), 134'(2'b01));
      chk("nmac_tag1", 134'(got_nmac[1][133:128]), 134'(6'b100010));
    end

    // discards: bad type, outport 9, subtype 07, gap as head
    clear_stim();
    add_meta(); add_head(16'h0800, 8'h00, 8'h01); add_inner(2'b11, 4'd0); add_inner(2'b10, 4'd0);
    add_meta(); add_head(16'hff01, 8'h00, 8'h09); add_inner(2'b11, 4'd0); add_inner(2'b10, 4'd0);
    add_meta(); add_head(16'hff01, 8'h07, 8'h01); add_inner(2'b10, 4'd0);
    add_meta(); add_gap();
    run_test();
    chk("disc_cnt", 134'(ov_discard_cnt), 134'd4);
    chk("disc_tsmp", 134'(ov_tsmp_cnt), 134'd2);
    chk("disc_out", 134'(got_port.size() + got_nmac.size()), 134'd0);

    // gap truncation, then truncation by a new metadata word
    clear_stim();
    add_meta(); add_head(16'hff01, 8'h00, 8'h02);
    add_inner(2'b11, 4'd0); add_inner(2'b11, 4'd0); add_gap(); add_inner(2'b10, 4'd0);
    add_meta(); add_head(16'hff01, 8'h05, 8'h00);
    add_inner(2'b11, 4'd0); add_meta(); add_inner(2'b10, 4'd0);
    run_test();
    chk("gap_len", 134'(got_port.size()), 134'd5);
    if (got_port.size() == 5) chk("gap_last", 134'(got_port[2][133:128]), 134'(6'b100000));
    chk("gap_pulses", 134'(trunc_seen), 134'd2);

    // back-to-back ARP frames
    clear_stim();
    add_meta(); add_head(16'hff01, 8'h00, 8'h01);
    add_inner(2'b11, 4'd0); add_inner(2'b11, 4'd0); add_inner(2'b10, 4'd8);
    add_meta(); add_head(16'hff01, 8'h00, 8'h08);
    add_inner(2'b11, 4'd0); add_inner(2'b10, 4'd0);
    run_test();
    chk("b2b_len", 134'(got_port.size()), 134'd7);
    if (got_port.size() == 7) chk("b2b_mask8", 134'(got_port[4][119:111]), 134'(9'h100));

    // reset in the middle of a forwarded frame
    clear_stim();
    add_meta(); add_head(16'hff01, 8'h00, 8'h04);
    add_inner(2'b11, 4'd0); add_inner(2'b11, 4'd0); add_inner(2'b11, 4'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk);
      #1;
      i_data_wr = s_wr[k];
      iv_data   = s_d[k];
    end
    #2;
    chk("pre_reset_wr", 134'(o_data_wr), 134'd1);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    i_data_wr = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    m_tsmp = '0;
    m_disc = '0;
    clear_stim();
    add_meta(); add_head(16'hff01, 8'h00, 8'h06);
    add_inner(2'b11, 4'd0); add_inner(2'b10, 4'd1);
    run_test();
    chk("post_reset_len", 134'(got_port.size()), 134'd3);
    chk("post_reset_tsmp", 134'(ov_tsmp_cnt), 134'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
